// File: rtl/efi_virtual_crank_gen.sv
// efi_virtual_crank_gen
//   Builds a virtual N-M missing-tooth crank wheel from the config words held in
//   the efi_virtual_input register file. The EFI core uses it as a synthetic
//   engine-position input. Live config is copied into shadow registers only
//   when the generator starts, or at a revolution boundary, so a running tooth
//   train never changes pitch or tooth count part-way through a revolution.
//
// Optional feature macro: CAM_OUT_EN (adds the cam_out port and its logic).
//
// Ports
//   ACLK         in   clock
//   ARESETN      in   asynchronous active-low reset
//   cfg_enable   in   1 = run, 0 = stop and return to idle
//   cfg_period   in   ACLK cycles per tooth pitch (legal >= 2)
//   cfg_teeth    in   tooth positions per revolution incl. missing (legal >= 3)
//   cfg_missing  in   missing teeth at end of revolution (legal <= cfg_teeth-2)
//   cfg_update   in   one-cycle pulse: the register file wrote new config
//   crank_out    out  virtual crank signal
//   sync_pulse   out  one-cycle strobe on the first cycle of tooth 0
//   tooth_idx    out  current tooth position
//   rev_cnt      out  completed revolutions (wraps)
//   cfg_err      out  sticky illegal-config flag, cleared when enable drops
//   cam_out      out  (CAM_OUT_EN only) high through tooth 0 of even revolutions
module efi_virtual_crank_gen #(
  parameter int PERIOD_W = 32,
  parameter int TOOTH_W  = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cfg_enable,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [TOOTH_W-1:0]  cfg_teeth,
  input  logic [TOOTH_W-1:0]  cfg_missing,
  input  logic                cfg_update,
  output logic                crank_out,
  output logic                sync_pulse,
  output logic [TOOTH_W-1:0]  tooth_idx,
  output logic [31:0]         rev_cnt,
  output logic                cfg_err
`ifdef CAM_OUT_EN
  ,
  output logic                cam_out
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t               state_reg, state_next;
  logic [PERIOD_W-1:0]  phase_reg, phase_next;
  logic [TOOTH_W-1:0]   idx_reg, idx_next;
  logic [PERIOD_W-1:0]  shp_reg, shp_next;
  logic [TOOTH_W-1:0]   sht_reg, sht_next;
  logic [TOOTH_W-1:0]   shm_reg, shm_next;
  logic                 pend_reg, pend_next;
  // Set on the edge where idx wraps; the following edge is where the new
  // revolution's first cycle is emitted and rev_cnt must step.
  logic                 wrap_reg, wrap_next;
  logic                 crank_reg, crank_next;
  logic                 sync_reg, sync_next;
  logic [TOOTH_W-1:0]   tooth_reg, tooth_next;
  logic [31:0]          rev_reg, rev_next;
  logic                 err_reg, err_next;
`ifdef CAM_OUT_EN
  logic                 cam_reg, cam_next;
`endif

  logic live_legal;
  logic at_pitch_end;
  logic at_rev_end;

  function automatic logic cfg_legal(input logic [PERIOD_W-1:0] p,
                                     input logic [TOOTH_W-1:0]  t,
                                     input logic [TOOTH_W-1:0]  m);
    // One extra bit so m+2 cannot overflow for large m.
    return (p >= PERIOD_W'(2)) && (t >= TOOTH_W'(3)) &&
           (((TOOTH_W+1)'(m) + (TOOTH_W+1)'(2)) <= (TOOTH_W+1)'(t));
  endfunction

  assign live_legal   = cfg_legal(cfg_period, cfg_teeth, cfg_missing);
  assign at_pitch_end = (phase_reg == shp_reg - PERIOD_W'(1));
  assign at_rev_end   = at_pitch_end && (idx_reg == sht_reg - TOOTH_W'(1));

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    shp_next   = shp_reg;
    sht_next   = sht_reg;
    shm_next   = shm_reg;
    pend_next  = pend_reg;
    wrap_next  = 1'b0;
    crank_next = 1'b0;
    sync_next  = 1'b0;
    tooth_next = '0;
    rev_next   = rev_reg;
    err_next   = err_reg;
`ifdef CAM_OUT_EN
    cam_next   = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        phase_next = '0;
        idx_next   = '0;
        pend_next  = 1'b0;
        if (!cfg_enable) begin
          err_next = 1'b0;
        end else if (live_legal) begin
          shp_next   = cfg_period;
          sht_next   = cfg_teeth;
          shm_next   = cfg_missing;
          state_next = ST_RUN;
        end else begin
          err_next = 1'b1;
        end
      end

      ST_RUN: begin
        if (!cfg_enable) begin
          // Stop wins over everything; outputs fall through to their zero defaults.
          state_next = ST_IDLE;
          phase_next = '0;
          idx_next   = '0;
          pend_next  = 1'b0;
          err_next   = 1'b0;
        end else begin
          // Outputs are a registered image of the current counter position.
          crank_next = (phase_reg < (shp_reg >> 1)) && (idx_reg < (sht_reg - shm_reg));
          sync_next  = (phase_reg == '0) && (idx_reg == '0);
          tooth_next = idx_reg;
          if (sync_next && wrap_reg) begin
            rev_next = rev_reg + 32'd1;
          end
`ifdef CAM_OUT_EN
          cam_next = (idx_reg == '0) && !rev_next[0];
`endif

          if (at_pitch_end) begin
            phase_next = '0;
            idx_next   = at_rev_end ? '0 : idx_reg + TOOTH_W'(1);
          end else begin
            phase_next = phase_reg + PERIOD_W'(1);
          end

          if (at_rev_end) begin
            wrap_next = 1'b1;
            if (pend_reg) begin
              if (live_legal) begin
                shp_next = cfg_period;
                sht_next = cfg_teeth;
                shm_next = cfg_missing;
              end else begin
                err_next = 1'b1;
              end
            end
          end

          // An update landing on the wrap edge itself is kept for the next wrap.
          if (cfg_update) begin
            pend_next = 1'b1;
          end else if (at_rev_end) begin
            pend_next = 1'b0;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      idx_reg   <= '0;
      shp_reg   <= '0;
      sht_reg   <= '0;
      shm_reg   <= '0;
      pend_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      crank_reg <= 1'b0;
      sync_reg  <= 1'b0;
      tooth_reg <= '0;
      rev_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef CAM_OUT_EN
      cam_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      idx_reg   <= idx_next;
      shp_reg   <= shp_next;
      sht_reg   <= sht_next;
      shm_reg   <= shm_next;
      pend_reg  <= pend_next;
      wrap_reg  <= wrap_next;
      crank_reg <= crank_next;
      sync_reg  <= sync_next;
      tooth_reg <= tooth_next;
      rev_reg   <= rev_next;
      err_reg   <= err_next;
`ifdef CAM_OUT_EN
      cam_reg   <= cam_next;
`endif
    end
  end

  assign crank_out  = crank_reg;
  assign sync_pulse = sync_reg;
  assign tooth_idx  = tooth_reg;
  assign rev_cnt    = rev_reg;
  assign cfg_err    = err_reg;
`ifdef CAM_OUT_EN
  assign cam_out    = cam_reg;
`endif

endmodule

// File: tb/tb_efi_virtual_crank_gen.sv
// Testbench for efi_virtual_crank_gen: expected per-cycle outputs are pushed
// to a queue from the wheel geometry, then popped and compared each cycle.
module tb_efi_virtual_crank_gen;

  logic        ACLK;
  logic        ARESETN;
  logic        cfg_enable;
  logic [31:0] cfg_period;
  logic [7:0]  cfg_teeth;
  logic [7:0]  cfg_missing;
  logic        cfg_update;
  logic        crank_out;
  logic        sync_pulse;
  logic [7:0]  tooth_idx;
  logic [31:0] rev_cnt;
  logic        cfg_err;
`ifdef CAM_OUT_EN
  logic        cam_out;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        crank;
    logic        sync;
    logic [7:0]  idx;
    logic [31:0] rev;
  } exp_t;

  exp_t exp_q[$];

  efi_virtual_crank_gen #(.PERIOD_W(32), .TOOTH_W(8)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_enable  (cfg_enable),
    .cfg_period  (cfg_period),
    .cfg_teeth   (cfg_teeth),
    .cfg_missing (cfg_missing),
    .cfg_update  (cfg_update),
    .crank_out   (crank_out),
    .sync_pulse  (sync_pulse),
    .tooth_idx   (tooth_idx),
    .rev_cnt     (rev_cnt),
    .cfg_err     (cfg_err)
`ifdef CAM_OUT_EN
    ,
    .cam_out     (cam_out)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs for n consecutive cycles of a wheel starting at tooth 0.
  task automatic push_exp(input int p, input int t, input int m, input int rev0, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int w;
      w       = k % (p * t);
      e.idx   = 8'(w / p);
      e.crank = ((w % p) < (p / 2)) && ((w / p) < (t - m));
      e.sync  = (w == 0);
      e.rev   = 32'(rev0 + k / (p * t));
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN    = 1'b0;
    cfg_enable = 1'b0;
    cfg_update = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  // Drive config and enable; returns at the negedge just before tooth 0's first cycle.
  task automatic start(input int p, input int t, input int m);
    @(negedge ACLK);
    cfg_period  = 32'(p);
    cfg_teeth   = 8'(t);
    cfg_missing = 8'(m);
    cfg_enable  = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    #12;
    checks++;
    if (crank_out !== 1'b0 || sync_pulse !== 1'b0 || tooth_idx !== 8'd0 ||
        rev_cnt !== 32'd0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got crank=%b sync=%b idx=%0d rev=%0d err=%b want all 0",
               crank_out, sync_pulse, tooth_idx, rev_cnt, cfg_err);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if (crank_out !== 1'b0 || sync_pulse !== 1'b0 || tooth_idx !== 8'd0 ||
        rev_cnt !== 32'd0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got crank=%b sync=%b idx=%0d rev=%0d err=%b want all 0",
               crank_out, sync_pulse, tooth_idx, rev_cnt, cfg_err);
    end
    $display("reset: done");
  endtask

  task automatic test_basic();
    exp_t e;
    do_reset();
    start(4, 6, 1);
    push_exp(4, 6, 1, 0, 49);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx ||
          rev_cnt !== e.rev || cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL basic cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d err=%b want crank=%b sync=%b idx=%0d rev=%0d err=0",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, cfg_err, e.crank, e.sync, e.idx, e.rev);
      end
      if (e.sync) $display("basic: rev start cyc=%0d rev_cnt=%0d", k, rev_cnt);
    end
  endtask

  task automatic test_odd_pitch();
    exp_t e;
    do_reset();
    start(5, 4, 1);
    push_exp(5, 4, 1, 0, 21);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx ||
          rev_cnt !== e.rev || cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL odd_pitch cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d want crank=%b sync=%b idx=%0d rev=%0d",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, e.crank, e.sync, e.idx, e.rev);
      end
      if (e.sync) $display("odd_pitch: rev start cyc=%0d rev_cnt=%0d", k, rev_cnt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    // Pitch of 1 is illegal.
    start(1, 6, 1);
    repeat (3) @(negedge ACLK);
    checks++;
    if (cfg_err !== 1'b1 || crank_out !== 1'b0 || sync_pulse !== 1'b0 || tooth_idx !== 8'd0) begin
      failures++;
      $display("FAIL illegal_p1 got err=%b crank=%b sync=%b idx=%0d want err=1 crank=0 sync=0 idx=0",
               cfg_err, crank_out, sync_pulse, tooth_idx);
    end
    cfg_enable = 1'b0;
    @(negedge ACLK);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_p1_clear got err=%b want 0", cfg_err);
    end
    // Missing = teeth-1 is illegal.
    start(4, 6, 5);
    repeat (2) @(negedge ACLK);
    checks++;
    if (cfg_err !== 1'b1 || crank_out !== 1'b0 || sync_pulse !== 1'b0) begin
      failures++;
      $display("FAIL illegal_m got err=%b crank=%b sync=%b want err=1 crank=0 sync=0",
               cfg_err, crank_out, sync_pulse);
    end
    cfg_enable = 1'b0;
    @(negedge ACLK);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_m_clear got err=%b want 0", cfg_err);
    end
    // Missing = teeth-2 is the legal boundary.
    start(4, 6, 4);
    @(negedge ACLK);
    checks++;
    if (cfg_err !== 1'b0 || crank_out !== 1'b1 || sync_pulse !== 1'b1) begin
      failures++;
      $display("FAIL legal_m_boundary got err=%b crank=%b sync=%b want err=0 crank=1 sync=1",
               cfg_err, crank_out, sync_pulse);
    end
    $display("illegal: done");
  endtask

  task automatic test_mid_rev_update();
    exp_t e;
    do_reset();
    start(4, 6, 1);
    push_exp(4, 6, 1, 0, 24);
    push_exp(8, 6, 1, 1, 49);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx ||
          rev_cnt !== e.rev || cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL mid_rev_update cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d want crank=%b sync=%b idx=%0d rev=%0d",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, e.crank, e.sync, e.idx, e.rev);
      end
      if (e.sync) $display("mid_rev_update: rev start cyc=%0d rev_cnt=%0d", k, rev_cnt);
      // Write the new pitch while tooth 2 is on the output.
      cfg_update = (k == 9);
      if (k == 9) cfg_period = 32'd8;
    end
    cfg_update = 1'b0;
  endtask

  task automatic test_update_at_wrap();
    exp_t e;
    do_reset();
    start(4, 6, 1);
    push_exp(4, 6, 1, 0, 48);
    push_exp(6, 6, 1, 2, 37);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx ||
          rev_cnt !== e.rev || cfg_err !== 1'b0) begin
        failures++;
        $display("FAIL update_at_wrap cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d want crank=%b sync=%b idx=%0d rev=%0d",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, e.crank, e.sync, e.idx, e.rev);
      end
      if (e.sync) $display("update_at_wrap: rev start cyc=%0d rev_cnt=%0d", k, rev_cnt);
      // Pulse lands on the wrap edge of revolution 0.
      cfg_update = (k == 22);
      if (k == 22) cfg_period = 32'd6;
    end
    cfg_update = 1'b0;
  endtask

  task automatic test_disable_and_reset();
    exp_t e;
    do_reset();
    start(4, 6, 1);
    push_exp(4, 6, 1, 0, 37);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx || rev_cnt !== e.rev) begin
        failures++;
        $display("FAIL disable_run cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d want crank=%b sync=%b idx=%0d rev=%0d",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, e.crank, e.sync, e.idx, e.rev);
      end
    end
    // Tooth 3 of revolution 1 is on the output; drop enable.
    cfg_enable = 1'b0;
    @(negedge ACLK);
    checks++;
    if (crank_out !== 1'b0 || sync_pulse !== 1'b0 || tooth_idx !== 8'd0 || rev_cnt !== 32'd1) begin
      failures++;
      $display("FAIL disable_edge got crank=%b sync=%b idx=%0d rev=%0d want crank=0 sync=0 idx=0 rev=1",
               crank_out, sync_pulse, tooth_idx, rev_cnt);
    end
    $display("disable: stopped rev_cnt=%0d", rev_cnt);
    // Restart: fresh tooth 0, revolution count not bumped.
    start(4, 6, 1);
    push_exp(4, 6, 1, 1, 13);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      checks++;
      if (crank_out !== e.crank || sync_pulse !== e.sync || tooth_idx !== e.idx || rev_cnt !== e.rev) begin
        failures++;
        $display("FAIL restart cyc=%0d got crank=%b sync=%b idx=%0d rev=%0d want crank=%b sync=%b idx=%0d rev=%0d",
                 k, crank_out, sync_pulse, tooth_idx, rev_cnt, e.crank, e.sync, e.idx, e.rev);
      end
    end
    // Tooth 3 again; assert reset between clock edges.
    #2;
    ARESETN = 1'b0;
    #1;
    checks++;
    if (crank_out !== 1'b0 || sync_pulse !== 1'b0 || tooth_idx !== 8'd0 ||
        rev_cnt !== 32'd0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got crank=%b sync=%b idx=%0d rev=%0d err=%b want all 0",
               crank_out, sync_pulse, tooth_idx, rev_cnt, cfg_err);
    end
    $display("async_reset: outputs cleared");
    cfg_enable = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

`ifdef CAM_OUT_EN
  task automatic test_cam();
    exp_t e;
    logic want_cam;
    do_reset();
    start(4, 6, 1);
    push_exp(4, 6, 1, 0, 4 * 24 + 4);
    for (int k = 0; exp_q.size() > 0; k++) begin
      @(negedge ACLK);
      e = exp_q.pop_front();
      want_cam = (e.idx == 8'd0) && !e.rev[0];
      checks++;
      if (cam_out !== want_cam || rev_cnt !== e.rev) begin
        failures++;
        $display("FAIL cam cyc=%0d got cam=%b rev=%0d want cam=%b rev=%0d",
                 k, cam_out, rev_cnt, want_cam, e.rev);
      end
    end
    $display("cam: done");
  endtask
`endif

  initial begin
    ARESETN     = 1'b0;
    cfg_enable  = 1'b0;
    cfg_period  = 32'd0;
    cfg_teeth   = 8'd0;
    cfg_missing = 8'd0;
    cfg_update  = 1'b0;
    test_reset();
    test_basic();
    test_odd_pitch();
    test_illegal();
    test_mid_rev_update();
    test_update_at_wrap();
    test_disable_and_reset();
`ifdef CAM_OUT_EN
    test_cam();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
